// File: rtl/mem_req_ctrl.sv
// Initiator for the MainMemory port: one read, write or evict+fill at a time over valid/ready.
// Read rsp_valid 3 edges after accept, error 1 edge; the response holds until rsp_ready and req_ready is low meanwhile.
module mem_req_ctrl #(
  parameter int DATA_W   = 64,
  parameter int IDX_W    = 8,
  parameter int PAGE_W   = 1,
  parameter int MAX_PAGE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [PAGE_W-1:0] req_page,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [PAGE_W-1:0] vic_page,
  input  logic [IDX_W-1:0]  vic_idx,
  input  logic [DATA_W-1:0] vic_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PAGE_W-1:0] mem_page,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    WR      = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_EVF = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // One spare bit keeps the range check meaningful when MAX_PAGE is the top page.
  localparam logic [PAGE_W:0] MAX_PAGE_X = (PAGE_W+1)'(MAX_PAGE);

  state_e              state_q;
  logic [PAGE_W-1:0]   tgt_page_q;
  logic [IDX_W-1:0]    tgt_idx_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [PAGE_W-1:0]   mem_page_q;
  logic [IDX_W-1:0]    mem_idx_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic req_page_bad;
  logic vic_page_bad;
  logic bad_req;

  assign req_page_bad = {1'b0, req_page} > MAX_PAGE_X;
  assign vic_page_bad = {1'b0, vic_page} > MAX_PAGE_X;
  assign bad_req      = (req_op == OP_RSV) || req_page_bad ||
                        ((req_op == OP_EVF) && vic_page_bad);

  // Decoded from state so a synchronous reset kills the strobe in the same cycle.
  assign req_ready = (state_q == IDLE) && !reset;
  assign mem_we    = ((state_q == WR) || (state_q == WB)) && !reset;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_page  = mem_page_q;
  assign mem_idx   = mem_idx_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_page_q  <= '0;
      tgt_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_page_q  <= '0;
      mem_idx_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            tgt_page_q <= req_page;
            tgt_idx_q  <= req_idx;
            if (bad_req) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RSP;
            end else begin
              rsp_err_q <= 1'b0;
              case (req_op)
                OP_RD: begin
                  mem_page_q <= req_page;
                  mem_idx_q  <= req_idx;
                  state_q    <= RD_ADDR;
                end
                OP_WR: begin
                  mem_page_q  <= req_page;
                  mem_idx_q   <= req_idx;
                  mem_wdata_q <= req_wdata;
                  state_q     <= WR;
                end
                default: begin
                  mem_page_q  <= vic_page;
                  mem_idx_q   <= vic_idx;
                  mem_wdata_q <= vic_data;
                  state_q     <= WB;
                end
              endcase
            end
          end
        end
        // Victim write lands on this edge, so a same-address fill reads it back.
        WB: begin
          mem_page_q <= tgt_page_q;
          mem_idx_q  <= tgt_idx_q;
          state_q    <= RD_ADDR;
        end
        WR: begin
          rsp_rdata_q <= '0;
          state_q     <= RSP;
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          rsp_rdata_q <= mem_rdata;
          state_q     <= RSP;
        end
        RSP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
